// File: rtl/pupil_bbox_tracker_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the binarised-image stream stages.
//   PIX_W          : pixel data width of the binarised stream
//   OBJ_PIX        : pixel value marking an object (dark) pixel
//   DEF_H_BITS/..  : default counter widths, large enough for 640x480
//   state_t        : tracker FSM state encoding (IDLE / ACTIVE / REPORT)
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_W = 10;
    localparam logic [PIX_W-1:0] OBJ_PIX = 10'd0;

    localparam int DEF_H_BITS     = 10;
    localparam int DEF_V_BITS     = 10;
    localparam int DEF_MIN_PIXELS = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACTIVE = 2'd1;
    localparam state_t REPORT = 2'd2;

endpackage

// File: rtl/pupil_bbox_tracker_if.sv
// -----------------------------------------------------------------------------
// pupil_bbox_tracker_if
// Binarised pixel stream bundle.
//   fval : frame valid, high for the whole active frame
//   dval : pixel valid, high across each active line
//   data : binarised pixel (0 = object, 10'h3FF = background)
// Modports: master drives the stream, slave consumes it.
// -----------------------------------------------------------------------------
interface pupil_bbox_tracker_if;
    import img_pkg::*;

    logic             fval;
    logic             dval;
    logic [PIX_W-1:0] data;

    modport master (output fval, dval, data);
    modport slave  (input  fval, dval, data);

endinterface

// File: rtl/pupil_bbox_tracker_edge_det.sv
// -----------------------------------------------------------------------------
// stream_edge_det
// Registers frame/line valid and emits single-cycle boundary pulses.
//   iCLK, iRST  : clock, synchronous active-high reset (clears history)
//   iFVAL       : frame valid
//   iDVAL       : line/pixel valid
//   frameStart  : iFVAL rising  (iFVAL & ~fvalD)
//   frameEnd    : iFVAL falling (~iFVAL & fvalD)
//   lineEnd     : iDVAL falling (~iDVAL & dvalD)
// -----------------------------------------------------------------------------
module stream_edge_det (
    input  logic iCLK,
    input  logic iRST,
    input  logic iFVAL,
    input  logic iDVAL,
    output logic frameStart,
    output logic frameEnd,
    output logic lineEnd
);

    logic fvalD;
    logic dvalD;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fvalD <= 1'b0;
            dvalD <= 1'b0;
        end else begin
            fvalD <= iFVAL;
            dvalD <= iDVAL;
        end
    end

    assign frameStart =  iFVAL & ~fvalD;
    assign frameEnd   = ~iFVAL &  fvalD;
    assign lineEnd    = ~iDVAL &  dvalD;

endmodule

// File: rtl/pupil_bbox_tracker.sv
// -----------------------------------------------------------------------------
// pupil_bbox_tracker
// Per-frame bounding box and pixel count of object (iDATA==0) pixels in the
// binarised stream; results published at frame end and held until the next.
//   iCLK, iRST        : clock, synchronous active-high reset
//   pix (slave)       : binarised stream (fval, dval, data)
//   oX_MIN / oX_MAX   : leftmost / rightmost object column of last frame
//   oY_MIN / oY_MAX   : top / bottom object row of last frame
//   oCOUNT            : object pixel count (saturating)
//   oFOUND            : oCOUNT >= MIN_PIXELS
//   oVALID            : one-cycle pulse when new results appear
// -----------------------------------------------------------------------------
module pupil_bbox_tracker
    import img_pkg::*;
#(
    parameter int H_BITS     = DEF_H_BITS,
    parameter int V_BITS     = DEF_V_BITS,
    parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    pupil_bbox_tracker_if.slave      pix,
    output logic [H_BITS-1:0]        oX_MIN,
    output logic [H_BITS-1:0]        oX_MAX,
    output logic [V_BITS-1:0]        oY_MIN,
    output logic [V_BITS-1:0]        oY_MAX,
    output logic [H_BITS+V_BITS-1:0] oCOUNT,
    output logic                     oFOUND,
    output logic                     oVALID
);

    localparam int CNT_W = H_BITS + V_BITS;

    localparam logic [H_BITS-1:0] X_ONE   = H_BITS'(1);
    localparam logic [V_BITS-1:0] Y_ONE   = V_BITS'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MIN = CNT_W'(MIN_PIXELS);

    logic frameStart;
    logic frameEnd;
    logic lineEnd;

    stream_edge_det u_edgeDet (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iFVAL      (pix.fval),
        .iDVAL      (pix.dval),
        .frameStart (frameStart),
        .frameEnd   (frameEnd),
        .lineEnd    (lineEnd)
    );

    state_t              state;
    logic                armed;
    logic [H_BITS-1:0]   xPos, xMin, xMax;
    logic [V_BITS-1:0]   yPos, yMin, yMax;
    logic [CNT_W-1:0]    pixCnt;

    logic                pixValid;
    logic                objPix;
    logic                startOk;
    logic                accumEn;
    logic [H_BITS-1:0]   baseX, baseXMin, baseXMax;
    logic [V_BITS-1:0]   baseY, baseYMin, baseYMax;
    logic [CNT_W-1:0]    baseCnt;
    logic [H_BITS-1:0]   nextX, nextXMin, nextXMax;
    logic [V_BITS-1:0]   nextY, nextYMin, nextYMax;
    logic [CNT_W-1:0]    nextCnt;

    always_comb begin
        pixValid = pix.fval & pix.dval;
        objPix   = pixValid & (pix.data == OBJ_PIX);

        // History is cleared by reset, so a frame already in progress at reset
        // release looks like a rising edge; armed only rises once iFVAL has
        // actually been seen low, which skips that partial frame.
        startOk  = frameStart & armed & (state != ACTIVE);
        accumEn  = startOk | ((state == ACTIVE) & ~frameEnd);

        // On the frame-start cycle the pixel is folded into freshly cleared
        // accumulators, so the update runs on the reset values instead.
        baseX    = startOk ? '0 : xPos;
        baseY    = startOk ? '0 : yPos;
        baseXMin = startOk ? '1 : xMin;
        baseXMax = startOk ? '0 : xMax;
        baseYMin = startOk ? '1 : yMin;
        baseYMax = startOk ? '0 : yMax;
        baseCnt  = startOk ? '0 : pixCnt;

        nextX    = baseX;
        nextY    = baseY;
        nextXMin = baseXMin;
        nextXMax = baseXMax;
        nextYMin = baseYMin;
        nextYMax = baseYMax;
        nextCnt  = baseCnt;

        if (pixValid) begin
            nextX = (baseX == '1) ? baseX : baseX + X_ONE;
            if (objPix) begin
                nextCnt  = (baseCnt == '1) ? baseCnt : baseCnt + CNT_ONE;
                nextXMin = (baseX < baseXMin) ? baseX : baseXMin;
                nextXMax = (baseX > baseXMax) ? baseX : baseXMax;
                nextYMin = (baseY < baseYMin) ? baseY : baseYMin;
                nextYMax = (baseY > baseYMax) ? baseY : baseYMax;
            end
        end else if (lineEnd && !startOk) begin
            nextX = '0;
            nextY = (baseY == '1) ? baseY : baseY + Y_ONE;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= IDLE;
            armed  <= 1'b0;
            xPos   <= '0;
            yPos   <= '0;
            xMin   <= '0;
            xMax   <= '0;
            yMin   <= '0;
            yMax   <= '0;
            pixCnt <= '0;
            oX_MIN <= '0;
            oX_MAX <= '0;
            oY_MIN <= '0;
            oY_MAX <= '0;
            oCOUNT <= '0;
            oFOUND <= 1'b0;
            oVALID <= 1'b0;
        end else begin
            if (!pix.fval) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE:    if (startOk)  state <= ACTIVE;
                ACTIVE:  if (frameEnd) state <= REPORT;
                REPORT:  state <= startOk ? ACTIVE : IDLE;
                default: state <= IDLE;
            endcase

            if (accumEn) begin
                xPos   <= nextX;
                yPos   <= nextY;
                xMin   <= nextXMin;
                xMax   <= nextXMax;
                yMin   <= nextYMin;
                yMax   <= nextYMax;
                pixCnt <= nextCnt;
            end

            oVALID <= (state == REPORT);
            if (state == REPORT) begin
                oCOUNT <= pixCnt;
                oFOUND <= (pixCnt >= CNT_MIN);
                // An empty frame reports a zero box rather than the sentinels.
                if (pixCnt == '0) begin
                    oX_MIN <= '0;
                    oX_MAX <= '0;
                    oY_MIN <= '0;
                    oY_MAX <= '0;
                end else begin
                    oX_MIN <= xMin;
                    oX_MAX <= xMax;
                    oY_MIN <= yMin;
                    oY_MAX <= yMax;
                end
            end
        end
    end

endmodule

// File: tb/tb_pupil_bbox_tracker.sv
// -----------------------------------------------------------------------------
// tb_pupil_bbox_tracker
// Drives directed frames into two trackers (MIN_PIXELS=1 and default 16)
// sharing one stream; expected reports are queued at frame end and a
// monitor pops/compares them on each oVALID, checking hold values otherwise.
// -----------------------------------------------------------------------------
module tb_pupil_bbox_tracker;
    import img_pkg::*;

    localparam int HB = 10;
    localparam int VB = 10;
    localparam int CW = HB + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pupil_bbox_tracker_if pixBus();

    logic [HB-1:0] aXMin, aXMax, bXMin, bXMax;
    logic [VB-1:0] aYMin, aYMax, bYMin, bYMax;
    logic [CW-1:0] aCount, bCount;
    logic          aFound, bFound, aVal, bVal;

    pupil_bbox_tracker #(.H_BITS(HB), .V_BITS(VB), .MIN_PIXELS(1)) dutA (
        .iCLK(clk), .iRST(rst), .pix(pixBus),
        .oX_MIN(aXMin), .oX_MAX(aXMax), .oY_MIN(aYMin), .oY_MAX(aYMax),
        .oCOUNT(aCount), .oFOUND(aFound), .oVALID(aVal)
    );

    pupil_bbox_tracker #(.H_BITS(HB), .V_BITS(VB), .MIN_PIXELS(16)) dutB (
        .iCLK(clk), .iRST(rst), .pix(pixBus),
        .oX_MIN(bXMin), .oX_MAX(bXMax), .oY_MIN(bYMin), .oY_MAX(bYMax),
        .oCOUNT(bCount), .oFOUND(bFound), .oVALID(bVal)
    );

    typedef struct {
        int xMin, xMax, yMin, yMax, cnt;
        int foundA, foundB;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t holdExp;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   objMap [16][8];

    function automatic void chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic exp_t mkExp(int x0, int x1, int y0, int y1, int n, int fa, int fb);
        exp_t e;
        e.xMin = x0; e.xMax = x1; e.yMin = y0; e.yMax = y1;
        e.cnt = n; e.foundA = fa; e.foundB = fb; e.cyc = 0;
        return e;
    endfunction

    function automatic void chkOut(string tag, exp_t e, int v);
        chk({tag, "_xmin_a"},  int'(aXMin),  e.xMin);
        chk({tag, "_xmax_a"},  int'(aXMax),  e.xMax);
        chk({tag, "_ymin_a"},  int'(aYMin),  e.yMin);
        chk({tag, "_ymax_a"},  int'(aYMax),  e.yMax);
        chk({tag, "_count_a"}, int'(aCount), e.cnt);
        chk({tag, "_found_a"}, int'(aFound), e.foundA);
        chk({tag, "_valid_a"}, int'(aVal),   v);
        chk({tag, "_xmin_b"},  int'(bXMin),  e.xMin);
        chk({tag, "_xmax_b"},  int'(bXMax),  e.xMax);
        chk({tag, "_ymin_b"},  int'(bYMin),  e.yMin);
        chk({tag, "_ymax_b"},  int'(bYMax),  e.yMax);
        chk({tag, "_count_b"}, int'(bCount), e.cnt);
        chk({tag, "_found_b"}, int'(bFound), e.foundB);
        chk({tag, "_valid_b"}, int'(bVal),   v);
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        exp_t e;
        logic rstS;
        holdExp = mkExp(0, 0, 0, 0, 0, 0, 0);
        forever begin
            @(posedge clk);
            cyc++;
            rstS = rst;
            #1;
            if (rstS) begin
                holdExp = mkExp(0, 0, 0, 0, 0, 0, 0);
                chkOut("reset", holdExp, 0);
            end else if (aVal || bVal) begin
                if (sbq.size() == 0) begin
                    chk("valid_without_frame", int'(aVal) + int'(bVal), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("report_latency_cycle", cyc, e.cyc);
                    chkOut("report", e, 1);
                    holdExp = e;
                end
            end else begin
                chkOut("hold", holdExp, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic f, input logic d, input logic [PIX_W-1:0] v);
        pixBus.fval = f;
        pixBus.dval = d;
        pixBus.data = v;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 10'h3FF);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearMap();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 8; y++)
                objMap[x][y] = 1'b0;
    endtask

    task automatic setObj(input int x, input int y);
        objMap[x][y] = 1'b1;
    endtask

    // One frame of w x h pixels taken from objMap. pixOnStart: fval and dval
    // rise together; tightEnd: last line's dval falls with fval; strayEnd:
    // dval=1/data=0 during the fval-low cycle. Returns at the negedge after
    // the fval-low cycle began, so a following call gives a 1-cycle gap.
    task automatic runFrame(input int w, input int h, input bit pixOnStart,
                            input bit tightEnd, input bit strayEnd,
                            input bit doPush, input exp_t e);
        exp_t q;
        if (!pixOnStart) begin
            drive(1'b1, 1'b0, 10'h3FF);
            tick();
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(1'b1, 1'b1, objMap[x][y] ? 10'd0 : 10'h3FF);
                tick();
            end
            if (!(tightEnd && y == h - 1)) begin
                drive(1'b1, 1'b0, 10'h3FF);
                tick();
                tick();
            end
        end
        drive(1'b0, strayEnd, strayEnd ? 10'd0 : 10'h3FF);
        if (doPush) begin
            q = e;
            q.cyc = cyc + 2;
            sbq.push_back(q);
        end
        tick();
    endtask

    initial begin : stimulus
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'h3FF);
        tick();
        tick();
        rst = 1'b0;
        idle(3);

        // Three scattered objects.
        clearMap();
        setObj(2, 1); setObj(5, 2); setObj(3, 3);
        runFrame(8, 4, 0, 0, 0, 1, mkExp(2, 5, 1, 3, 3, 1, 0));
        idle(4);

        // Empty frame; last line ends together with the frame.
        clearMap();
        runFrame(8, 4, 0, 1, 0, 1, mkExp(0, 0, 0, 0, 0, 0, 0));
        idle(4);

        // 15 then 16 object pixels around the default threshold.
        clearMap();
        for (int x = 0; x < 8; x++) setObj(x, 1);
        for (int x = 0; x < 7; x++) setObj(x, 2);
        runFrame(8, 4, 0, 0, 0, 1, mkExp(0, 7, 1, 2, 15, 1, 0));
        idle(8);
        clearMap();
        for (int y = 0; y < 4; y++)
            for (int x = 2; x < 6; x++) setObj(x, y);
        runFrame(8, 4, 1, 0, 0, 1, mkExp(2, 5, 0, 3, 16, 1, 1));
        idle(4);

        // Frame already running at reset release must be skipped.
        rst = 1'b1;
        drive(1'b1, 1'b0, 10'h3FF);
        tick();
        tick();
        rst = 1'b0;
        clearMap();
        setObj(0, 0); setObj(7, 3);
        runFrame(8, 4, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0));
        idle(3);
        clearMap();
        setObj(1, 1);
        runFrame(4, 2, 0, 0, 0, 1, mkExp(1, 1, 1, 1, 1, 1, 0));
        idle(4);

        // Reset in the middle of a line discards that frame.
        clearMap();
        setObj(6, 0);
        runFrame(8, 4, 0, 0, 0, 1, mkExp(6, 6, 0, 0, 1, 1, 0));
        idle(3);
        drive(1'b1, 1'b0, 10'h3FF);
        tick();
        for (int x = 0; x < 4; x++) begin
            drive(1'b1, 1'b1, (x == 0) ? 10'd0 : 10'h3FF);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, 10'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int x = 6; x < 8; x++) begin
            drive(1'b1, 1'b1, 10'd0);
            tick();
        end
        for (int y = 1; y < 4; y++) begin
            drive(1'b1, 1'b0, 10'h3FF);
            tick();
            tick();
            for (int x = 0; x < 8; x++) begin
                drive(1'b1, 1'b1, 10'd0);
                tick();
            end
        end
        drive(1'b1, 1'b0, 10'h3FF);
        tick();
        idle(3);
        clearMap();
        setObj(3, 0); setObj(0, 1);
        runFrame(4, 2, 0, 0, 0, 1, mkExp(0, 3, 0, 1, 2, 1, 0));
        idle(4);

        // Stray object pixels outside the frame, then back-to-back frames.
        drive(1'b0, 1'b1, 10'd0);
        tick();
        tick();
        tick();
        idle(2);
        clearMap();
        setObj(4, 2);
        runFrame(8, 4, 0, 0, 1, 1, mkExp(4, 4, 2, 2, 1, 1, 0));
        clearMap();
        setObj(0, 0); setObj(1, 3);
        runFrame(8, 4, 1, 0, 0, 1, mkExp(0, 1, 0, 3, 2, 1, 0));
        idle(8);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
